// File: rtl/rr_arb_weighted_if.sv
// Bus bundle for rr_arb_weighted: request/weight/pause in, grant out.
// The lock signal exists only when RR_ARB_LOCK_EN is defined.
interface rr_arb_weighted_if #(
  parameter int N  = 4,
  parameter int WW = 3,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]    req;
  logic [N*WW-1:0] weight;
  logic            pause;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   gnt_id;
  logic            gnt_last;
`ifdef RR_ARB_LOCK_EN
  logic            lock;

  modport master (output req, weight, pause, lock, input gnt, gnt_id, gnt_last);
  modport slave  (input req, weight, pause, lock, output gnt, gnt_id, gnt_last);
`else
  modport master (output req, weight, pause, input gnt, gnt_id, gnt_last);
  modport slave  (input req, weight, pause, output gnt, gnt_id, gnt_last);
`endif
endinterface

// File: rtl/rr_arb_weighted.sv
// Weighted round-robin arbiter with registered multi-cycle burst grants.
// A grant lasts weight[owner]+1 cycles (weight sampled at grant start),
// then passes to the next requester after the last released owner.
// pause blanks the grant and freezes all arbitration state.
// Optional feature macro: RR_ARB_LOCK_EN adds a lock input that holds the
// current burst until the owner drops its request.
module rr_arb_weighted #(
  parameter  int N  = 4,
  parameter  int WW = 3,
  localparam int IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_arb_weighted_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t        state_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] ptr_q;
  logic [WW-1:0] cnt_q;
  logic [N-1:0]  gnt_q;
  logic          gnt_last_q;

  logic          lock_s;
  logic [IW-1:0] pick_s;
  logic [WW-1:0] pick_w_s;
  logic [N-1:0]  pick_oh_s;
  logic [N-1:0]  own_oh_s;
  logic          release_s;
  logic          any_req_s;

`ifdef RR_ARB_LOCK_EN
  assign lock_s = bus.lock;
`else
  assign lock_s = 1'b0;
`endif

  // First set request bit strictly after index p, wrapping; p itself is last.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r,
                                            input logic [IW-1:0] p);
    logic [IW-1:0] idx;
    rr_pick = p;
    for (int i = N; i >= 1; i--) begin
      idx = IW'((int'(p) + i) % N);
      if (r[idx]) begin
        rr_pick = idx;
      end
    end
  endfunction

  // Search, release decision and the weight of the candidate winner.
  always_comb begin
    any_req_s = |bus.req;
    if (state_q == ST_GRANT) begin
      // On release ptr becomes owner, so search from the owner directly.
      pick_s = rr_pick(bus.req, owner_q);
    end else begin
      pick_s = rr_pick(bus.req, ptr_q);
    end
    pick_w_s  = bus.weight[int'(pick_s)*WW +: WW];
    pick_oh_s = {{(N-1){1'b0}}, 1'b1} << pick_s;
    own_oh_s  = {{(N-1){1'b0}}, 1'b1} << owner_q;
    release_s = ~bus.req[owner_q] | ((cnt_q == {WW{1'b0}}) & ~lock_s);
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= {IW{1'b0}};
      ptr_q      <= IW'(N-1);
      cnt_q      <= {WW{1'b0}};
      gnt_q      <= {N{1'b0}};
      gnt_last_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.pause) begin
            gnt_q      <= {N{1'b0}};
            gnt_last_q <= 1'b0;
          end else if (any_req_s) begin
            owner_q    <= pick_s;
            cnt_q      <= pick_w_s;
            gnt_q      <= pick_oh_s;
            gnt_last_q <= (pick_w_s == {WW{1'b0}}) & ~lock_s;
            state_q    <= ST_GRANT;
          end else begin
            gnt_q      <= {N{1'b0}};
            gnt_last_q <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (bus.pause) begin
            // Everything holds; a coinciding burst end is deferred.
            gnt_q      <= {N{1'b0}};
            gnt_last_q <= 1'b0;
          end else if (release_s) begin
            ptr_q <= owner_q;
            if (any_req_s) begin
              // Back-to-back handover, no idle bubble.
              owner_q    <= pick_s;
              cnt_q      <= pick_w_s;
              gnt_q      <= pick_oh_s;
              gnt_last_q <= (pick_w_s == {WW{1'b0}}) & ~lock_s;
            end else begin
              gnt_q      <= {N{1'b0}};
              gnt_last_q <= 1'b0;
              state_q    <= ST_IDLE;
            end
          end else if (lock_s) begin
            gnt_q      <= own_oh_s;
            gnt_last_q <= 1'b0;
          end else begin
            cnt_q      <= cnt_q - WW'(1);
            gnt_q      <= own_oh_s;
            gnt_last_q <= (cnt_q == WW'(1));
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          gnt_q      <= {N{1'b0}};
          gnt_last_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.gnt_id   = owner_q;
  assign bus.gnt_last = gnt_last_q;

endmodule

// File: tb/tb_rr_arb_weighted.sv
// Directed testbench for rr_arb_weighted (N=4, WW=3).
module tb_rr_arb_weighted;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  rr_arb_weighted_if #(.N(4), .WW(3)) bif ();

  rr_arb_weighted #(.N(4), .WW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_w(input logic [2:0] w0, input logic [2:0] w1,
                       input logic [2:0] w2, input logic [2:0] w3);
    bif.weight = {w3, w2, w1, w0};
  endtask

  // Advance one edge, then sample just after it.
  task automatic step_chk(input string tag, input logic [3:0] g, input logic l, input logic [1:0] id);
    @(posedge clk);
    #1;
    check_eq({tag, ".gnt"}, 32'(bif.gnt), 32'(g));
    check_eq({tag, ".last"}, 32'(bif.gnt_last), 32'(l));
    if (g != 4'b0000) begin
      check_eq({tag, ".id"}, 32'(bif.gnt_id), 32'(id));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    bif.req   = 4'b0000;
    bif.pause = 1'b0;
    set_w(3'd0, 3'd0, 3'd0, 3'd0);
`ifdef RR_ARB_LOCK_EN
    bif.lock  = 1'b0;
`endif
    #1;
    check_eq("rst.gnt", 32'(bif.gnt), 32'h0);
    check_eq("rst.id", 32'(bif.gnt_id), 32'h0);
    check_eq("rst.last", 32'(bif.gnt_last), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    bif.req   = 4'b0000;
    bif.pause = 1'b0;
    bif.weight = 12'h000;
`ifdef RR_ARB_LOCK_EN
    bif.lock  = 1'b0;
`endif

    // Plain rotation, single-cycle bursts.
    do_reset();
    bif.req = 4'b1111;
    step_chk("rot0", 4'b0001, 1'b1, 2'd0);
    step_chk("rot1", 4'b0010, 1'b1, 2'd1);
    step_chk("rot2", 4'b0100, 1'b1, 2'd2);
    step_chk("rot3", 4'b1000, 1'b1, 2'd3);
    step_chk("rot4", 4'b0001, 1'b1, 2'd0);

    // Weighted bursts: 0 for 3 cycles, 2 for 2 cycles, then 0 again.
    do_reset();
    bif.req = 4'b0101;
    set_w(3'd2, 3'd0, 3'd1, 3'd0);
    step_chk("w.c1", 4'b0001, 1'b0, 2'd0);
    set_w(3'd7, 3'd0, 3'd1, 3'd0);   // mid-burst weight change must not matter
    step_chk("w.c2", 4'b0001, 1'b0, 2'd0);
    step_chk("w.c3", 4'b0001, 1'b1, 2'd0);
    set_w(3'd2, 3'd0, 3'd1, 3'd0);
    step_chk("w.c4", 4'b0100, 1'b0, 2'd2);
    step_chk("w.c5", 4'b0100, 1'b1, 2'd2);
    step_chk("w.c6", 4'b0001, 1'b0, 2'd0);
    bif.req = 4'b0000;               // owner drops, nobody waiting
    step_chk("w.idle", 4'b0000, 1'b0, 2'd0);
    step_chk("w.idle2", 4'b0000, 1'b0, 2'd0);

    // Early release when the owner drops its request.
    do_reset();
    bif.req = 4'b1010;
    set_w(3'd0, 3'd5, 3'd0, 3'd0);
    step_chk("drop.c1", 4'b0010, 1'b0, 2'd1);
    step_chk("drop.c2", 4'b0010, 1'b0, 2'd1);
    bif.req = 4'b1000;
    step_chk("drop.hand", 4'b1000, 1'b1, 2'd3);

    // Pause inside a 4-cycle burst of owner 0.
    do_reset();
    bif.req = 4'b0011;
    set_w(3'd3, 3'd0, 3'd0, 3'd0);
    step_chk("pz.c1", 4'b0001, 1'b0, 2'd0);
    step_chk("pz.c2", 4'b0001, 1'b0, 2'd0);
    bif.pause = 1'b1;
    step_chk("pz.p1", 4'b0000, 1'b0, 2'd0);
    step_chk("pz.p2", 4'b0000, 1'b0, 2'd0);
    bif.pause = 1'b0;
    step_chk("pz.c3", 4'b0001, 1'b0, 2'd0);
    step_chk("pz.c4", 4'b0001, 1'b1, 2'd0);
    bif.pause = 1'b1;                // pause coincides with burst end
    step_chk("pz.defer", 4'b0000, 1'b0, 2'd0);
    bif.pause = 1'b0;
    step_chk("pz.next", 4'b0010, 1'b1, 2'd1);

    // Sole requester re-wins every cycle, then async reset mid-stream.
    do_reset();
    bif.req = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step_chk($sformatf("sole%0d", i), 4'b1000, 1'b1, 2'd3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst.gnt", 32'(bif.gnt), 32'h0);
    check_eq("arst.id", 32'(bif.gnt_id), 32'h0);
    check_eq("arst.last", 32'(bif.gnt_last), 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    bif.req = 4'b1001;
    step_chk("arst.first", 4'b0001, 1'b1, 2'd0);

`ifdef RR_ARB_LOCK_EN
    // Lock holds owner 2 despite competing requests and weight 0.
    do_reset();
    bif.req  = 4'b0100;
    bif.lock = 1'b1;
    step_chk("lk.c1", 4'b0100, 1'b0, 2'd2);
    bif.req = 4'b1111;
    for (int i = 2; i <= 6; i++) begin
      step_chk($sformatf("lk.c%0d", i), 4'b0100, 1'b0, 2'd2);
    end
    bif.lock = 1'b0;
    step_chk("lk.rel", 4'b1000, 1'b1, 2'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
